// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 4-way round-robin arbiter:
//   arb_state_e  - FSM state encoding (IDLE, GRANT)
//   NREQ         - number of requesters (4)
//   IDX_W        - width of a requester index (2)
//   idx2onehot() - index to one-hot grant vector
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotated priority selector. The search starts at index ptr and
// proceeds ptr+1, ptr+2, ptr+3 (mod 4); the first set request wins.
// Ports:
//   req   [3:0] in   request vector, bit i = requester i
//   ptr   [1:0] in   highest-priority index
//   valid       out  at least one request is set
//   idx   [1:0] out  index of the winning requester (0 when valid=0)
// -----------------------------------------------------------------------------
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // rot[k] is the request that sits k places after ptr in search order.
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      // 2-bit addition wraps naturally, giving the mod-4 rotation.
      assign rot[gi] = req[ptr + IDX_W'(gi)];
    end
  endgenerate

  always_comb begin
    off = '0;
    // Walk from the lowest priority upward so the last hit is the first
    // set bit in search order.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  assign valid = |req;
  assign idx   = valid ? (ptr + off) : '0;

endmodule

// File: rtl/arb4_rr.sv
// -----------------------------------------------------------------------------
// arb4_rr
// Four-requester round-robin arbiter with a held grant. A grant is issued from
// IDLE (or directly on release) and kept until the owner asserts done. On
// release the priority pointer moves one past the owner, so the owner is
// searched last and a waiting requester is granted with no idle gap.
//
// Optional feature: define ARB4_RR_TIMEOUT_EN to enable a grant watchdog that
// force-releases a grant after TIMEOUT cycles without done and pulses timeout.
//
// Parameters:
//   TIMEOUT  watchdog limit in GRANT cycles (2..255), used only with the macro
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   enables new grants (does not affect a held grant)
//   req    [3:0] in   level requests
//   done         in   owner releases the resource (ignored in IDLE)
//   gnt    [3:0] out  registered one-hot grant, zero when idle
//   gnt_id [1:0] out  registered index of the granted requester, zero when idle
//   busy         out  high while a grant is held
//   timeout      out  one-cycle pulse after a watchdog release
// -----------------------------------------------------------------------------
module arb4_rr
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;

  logic             release_w;
  logic             wd_fire;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  // On a release the search must already use the advanced pointer so the
  // re-arbitration in the same cycle skips the releasing owner first.
  assign release_w = (state_q == GRANT) && (done || wd_fire);
  assign pick_ptr  = release_w ? (gnt_id_q + IDX_W'(1)) : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          state_d  = GRANT;
          gnt_d    = idx2onehot(pick_idx);
          gnt_id_d = pick_idx;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d = pick_ptr;
          if (en && pick_valid) begin
            gnt_d    = idx2onehot(pick_idx);
            gnt_id_d = pick_idx;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

`ifdef ARB4_RR_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // done in the same cycle wins over the watchdog.
  assign wd_fire = (state_q == GRANT) && !done && (cnt_q == WD_LAST);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = wd_fire;
    if (state_q == GRANT && !release_w) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      // Any new grant (from IDLE or on release) starts a fresh count.
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;

  // TIMEOUT has no effect in this build; the empty block only flags a
  // value outside its legal range during elaboration review.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end
`endif

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_arb4_rr.sv
// -----------------------------------------------------------------------------
// tb_arb4_rr
// Directed bench for arb4_rr. Each step drives inputs just after a rising
// edge, advances one edge, then checks all outputs against hand-computed
// values. Builds with or without ARB4_RR_TIMEOUT_EN (TIMEOUT=4).
// -----------------------------------------------------------------------------
module tb_arb4_rr;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total;
  int bad;

  arb4_rr #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                     input logic eb, input logic et);
    total++;
    $display("step %s: gnt=%b id=%0d busy=%b timeout=%b", tag, gnt, gnt_id, busy, timeout);
    assert (gnt === eg && gnt_id === ei && busy === eb && timeout === et)
    else begin
      bad++;
      $error("FAIL %s: observed gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
             tag, gnt, gnt_id, busy, timeout, eg, ei, eb, et);
    end
  endtask

  initial begin
    logic [1:0] seq_ids [5];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    seq_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First grant after reset, ptr=0: 1010 -> requester 1.
    rst_n = 1'b1; en = 1'b1; req = 4'b1010;
    tick(); chk("first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Release of 1 -> ptr=2, search 2,3 -> requester 3, no idle gap.
    done = 1'b1;
    tick(); chk("rearb_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // All requesting, done held: 0,1,2,3,0 back-to-back.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_seq%0d", i), 4'(1 << seq_ids[i]), seq_ids[i], 1'b1, 1'b0);
    end

    // Release of 0 -> ptr=1, only req[2] -> requester 2.
    req = 4'b0100;
    tick(); chk("grant_2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Grant held with req dropped and en low.
    done = 1'b0; req = 4'b0000; en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
`ifdef ARB4_RR_TIMEOUT_EN
      if (i < 4)       chk($sformatf("hold2_%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
      else if (i == 4) chk("hold2_wd_idle", 4'b0000, 2'd0, 1'b0, 1'b1);
      else             chk("hold2_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
      chk($sformatf("hold2_%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
`endif
    end

    // done releases (default build) / is ignored in IDLE (watchdog build).
    done = 1'b1;
    tick(); chk("release_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // en low in IDLE blocks grants.
    done = 1'b0; req = 4'b0001; en = 1'b0;
    tick(); chk("en_low_blocks", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr=3 now. Sole requester 3 regranted back-to-back.
    en = 1'b1; req = 4'b1000;
    tick(); chk("grant_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("regrant3_%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
    end

    // Owner dropping its request does not release.
    done = 1'b0; req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick(); chk($sformatf("owner_drop_%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
    end

    // Release with en low but requests pending -> IDLE.
    req = 4'b0011; en = 1'b0; done = 1'b1;
    tick(); chk("release_en_low", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr=0: grant 0.
    done = 1'b0; en = 1'b1;
    tick(); chk("grant_0", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef ARB4_RR_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick(); chk($sformatf("wd_hold_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick(); chk("wd_release", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick(); chk($sformatf("wd_hold1_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    // done coincides with watchdog: treated as done, no pulse.
    done = 1'b1;
    tick(); chk("done_beats_wd", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b0;
`else
    for (int i = 0; i < 110; i++) begin
      tick(); chk($sformatf("long_hold_%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    // Release of 0 -> ptr=1, req 1001 -> requester 3.
    req = 4'b1001; done = 1'b1;
    tick(); chk("pre_reset_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b0;

    // Asynchronous reset between edges drops the grant at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr back to 0: 1001 -> requester 0.
    rst_n = 1'b1;
    tick(); chk("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 Parameter TIMEOUT, default 16, grant watchdog limit in cycles (range 2..255); used only when ARB4_RR_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  arbitration enable; low blocks new grants only.
REQ-005 req  input  4  request per requester, level, bit i = requester i.
REQ-006 done  input  1  current owner releases resource; sampled only in GRANT.
REQ-007 gnt  output  4  one-hot grant, registered, all-zero when idle.
REQ-008 gnt_id  output  2  binary index of granted requester, registered; 0 when idle.
REQ-009 busy  output  1  high while in GRANT.
REQ-010 timeout  output  1  one-cycle pulse on watchdog release; constant 0 without the macro.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE, GRANT.
REQ-012 Pointer ptr (2 bits) SHALL hold the highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-013 Selection SHALL be combinational (4-to-2 rotated priority encode); winner = first set bit of req in search order.
REQ-014 IDLE: if en=1 and req!=0 at edge N, SHALL enter GRANT with gnt/gnt_id = winner visible after edge N (1-cycle latency).
REQ-015 IDLE with en=0 or req=0: SHALL stay IDLE, gnt=0, gnt_id=0, busy=0.
REQ-016 GRANT: gnt SHALL stay constant until release, regardless of req or en changes (owner dropping req does not release).
REQ-017 Release SHALL occur on done=1 in GRANT (or watchdog, REQ-026); ptr SHALL become gnt_id+1 mod 4 at that edge.
REQ-018 On release with en=1 and another/any req set, SHALL re-arbitrate in the same cycle using the updated ptr and go GRANT->GRANT with new gnt after that edge (no idle gap).
REQ-019 Back-to-back rule: releasing owner is searched last, so it is regranted only if it is the sole requester.
REQ-020 On release with en=0 or req=0: SHALL go to IDLE, gnt=0.
REQ-021 done in IDLE SHALL be ignored.
REQ-022 gnt SHALL never have more than one bit set; gnt_id SHALL always equal the index of the set bit.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, timeout=0, watchdog count=0.
REQ-024 Reset mid-GRANT SHALL drop the grant with no done required; first grant after reset SHALL favour requester 0.
REQ-025 First arbitration SHALL occur on the first clk edge with rst_n=1.

Configuration
REQ-026 With ARB4_RR_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant entry, increment each GRANT cycle without done; on the edge where count reaches TIMEOUT-1 without done, grant SHALL release as for done and timeout SHALL pulse for the following cycle.
REQ-027 done and watchdog in the same cycle SHALL be treated as done (timeout stays 0).
REQ-028 Without ARB4_RR_TIMEOUT_EN: no counter logic, timeout tied 0, grant held indefinitely until done.

Structure
REQ-029 Shared package arb_pkg SHALL hold the state enum (IDLE, GRANT), requester count constant (4) and index width constant (2).
REQ-030 One sub-module rr_pick4 SHALL implement rotated priority selection (inputs req, ptr; outputs valid, idx); FSM and registers stay in arb4_rr.

Verification
REQ-031 Reset, en=1, req=4'b1010 -> gnt=4'b0010, gnt_id=1 one cycle later; busy=1.
REQ-032 Holding req=4'b1111, pulse done each grant -> grants cycle 0,1,2,3,0 with no idle cycle between.
REQ-033 Grant to 2, req drops to 0, en=0, done after 5 cycles -> gnt stays 4'b0100 for 5 cycles, then IDLE, gnt=0.
REQ-034 Only req[3] set, done pulsed repeatedly -> gnt_id=3 regranted each time back-to-back.
REQ-035 Macro on, TIMEOUT=4, grant held without done -> release after 4 GRANT cycles, timeout=1 for one cycle, next requester granted; macro off -> grant held for 100+ cycles.
REQ-036 rst_n pulled low mid-GRANT (asynchronous, between edges) -> gnt=0 immediately; after release req=4'b1001 -> gnt_id=0.
